// File: rtl/piezo_pkg.sv
// -----------------------------------------------------------------------------
// piezo_pkg
// Shared types and constants for the piezo transducer driver.
//   drv_state_t   : one-hot driver state (IDLE, PLAY, OVER)
//   PER_W, DUR_W  : widths of the note period and note duration inputs
//   TICK_CYC_DEF  : default clocks per duration tick (1/100 s at 50 MHz)
//   TICK_CYC_FAST : tick period used when PIEZO_FAST_SIM_EN is defined
// -----------------------------------------------------------------------------
package piezo_pkg;

   localparam int PER_W         = 15;
   localparam int DUR_W         = 8;
   localparam int TICK_CYC_DEF  = 500000;
   localparam int TICK_CYC_FAST = 50;

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      PLAY = 3'b010,
      OVER = 3'b100
   } drv_state_t;

endpackage

// File: rtl/piezo_tick_gen.sv
// -----------------------------------------------------------------------------
// piezo_tick_gen
// Duration prescaler: emits a one-cycle tick every tick period while enabled.
// Build option: when PIEZO_FAST_SIM_EN is defined the tick period is forced to
// TICK_CYC_FAST regardless of TICK_CYC, so full alarm sequences simulate fast.
// Ports:
//   clk       in  : clock
//   rst       in  : synchronous active-high reset
//   i_restart in  : synchronous restart of the prescaler (driven by clr)
//   i_en      in  : count enable; the prescaler is frozen while low
//   o_tick    out : one-cycle pulse on the last clock of each tick period
// -----------------------------------------------------------------------------
module piezo_tick_gen
   import piezo_pkg::*;
#(
   parameter int TICK_CYC = TICK_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_restart,
   input  logic i_en,
   output logic o_tick
);

`ifdef PIEZO_FAST_SIM_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   localparam int               TP    = FAST ? TICK_CYC_FAST : TICK_CYC;
   localparam int               CNT_W = (TP > 1) ? $clog2(TP) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TP - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == LAST);

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of the others; blocking here would create ordering
   // races between always_ff blocks.
   always_ff @(posedge clk) begin
      if (rst || i_restart) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   // A restart cycle never counts as a tick: the duration is being cleared.
   assign o_tick = i_en & w_last & ~i_restart;

endmodule

// File: rtl/piezo_drv.sv
// -----------------------------------------------------------------------------
// piezo_drv
// Complementary square-wave piezo driver for the alarm note sequencer.
// A clr strobe starts a note of period note_per clocks (0 or 1 = rest) lasting
// note_dur ticks; note_over is raised when the duration has expired and held
// until the next clr. Period and duration are used live, not latched.
// Build option: PIEZO_FAST_SIM_EN (applied inside piezo_tick_gen) shortens the
// tick period to TICK_CYC_FAST clocks; ports and FSM are unchanged.
// Ports:
//   clk       in  : 50 MHz clock
//   rst       in  : synchronous active-high reset (wins over clr)
//   clr       in  : restart counters and begin a note
//   note_per  in  : note period in clocks
//   note_dur  in  : note duration in ticks
//   note_over out : duration expired (registered level)
//   piezo     out : positive drive (registered)
//   piezo_n   out : negative drive (registered)
// -----------------------------------------------------------------------------
module piezo_drv
   import piezo_pkg::*;
#(
   parameter int TICK_CYC = TICK_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [PER_W-1:0] note_per,
   input  logic [DUR_W-1:0] note_dur,
   output logic             note_over,
   output logic             piezo,
   output logic             piezo_n
);

   drv_state_t       r_state,    w_state_nxt;
   logic [PER_W-1:0] r_freq_cnt, w_freq_nxt;
   logic [DUR_W-1:0] r_dur_cnt,  w_dur_nxt;
   logic             r_piezo,    w_piezo_nxt;
   logic             r_piezo_n,  w_piezo_n_nxt;
   logic             r_note_over, w_note_over_nxt;

   logic             w_tick;
   logic             w_sound;
   logic             w_high;
   logic [PER_W-1:0] w_per_m1;
   logic [PER_W-1:0] w_per_half;

   piezo_tick_gen #(
      .TICK_CYC (TICK_CYC)
   ) u_tick_gen (
      .clk       (clk),
      .rst       (rst),
      .i_restart (clr),
      .i_en      (r_state == PLAY),
      .o_tick    (w_tick)
   );

   assign w_per_m1   = note_per - PER_W'(1);
   assign w_per_half = note_per >> 1;
   assign w_sound    = (note_per >= PER_W'(2));

   // NOTE: every signal driven here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_freq_nxt  = r_freq_cnt;
      w_dur_nxt   = r_dur_cnt;

      case (r_state)
         IDLE: ;
         OVER: ;
         PLAY: begin
            // >= rather than == keeps the counter bounded if the period shrinks.
            w_freq_nxt = (r_freq_cnt >= w_per_m1) ? '0 : r_freq_cnt + 1'b1;
            if (w_tick && (r_dur_cnt != '1)) begin
               w_dur_nxt = r_dur_cnt + 1'b1;
            end
            // Comparing the post-tick count lets note_over land on the cycle
            // right after the final tick period completes.
            if (w_dur_nxt >= note_dur) begin
               w_state_nxt = OVER;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if (clr) begin
         w_state_nxt = PLAY;
         w_freq_nxt  = '0;
         w_dur_nxt   = '0;
      end

      // Outputs are computed from next-state values so the registered pins
      // line up with the counters they describe.
      w_high          = (w_freq_nxt < w_per_half);
      w_piezo_nxt     = (w_state_nxt == PLAY) && w_sound &&  w_high;
      w_piezo_n_nxt   = (w_state_nxt == PLAY) && w_sound && !w_high;
      w_note_over_nxt = (w_state_nxt == OVER);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_freq_cnt  <= '0;
         r_dur_cnt   <= '0;
         r_piezo     <= 1'b0;
         r_piezo_n   <= 1'b0;
         r_note_over <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_freq_cnt  <= w_freq_nxt;
         r_dur_cnt   <= w_dur_nxt;
         r_piezo     <= w_piezo_nxt;
         r_piezo_n   <= w_piezo_n_nxt;
         r_note_over <= w_note_over_nxt;
      end
   end

   assign note_over = r_note_over;
   assign piezo     = r_piezo;
   assign piezo_n   = r_piezo_n;

endmodule

// File: tb/tb_piezo_drv.sv
// -----------------------------------------------------------------------------
// tb_piezo_drv
// Self-checking bench for piezo_drv. The reference model derives the expected
// outputs from the number of edges since the last clr using plain arithmetic:
// the note ends at edge-count 1+D*T (2 for D = 0), and while sounding the
// positive side is high when (n-1) mod P < P/2.
// -----------------------------------------------------------------------------
module tb_piezo_drv;
   import piezo_pkg::*;

   localparam int TICK = 10;
`ifdef PIEZO_FAST_SIM_EN
   localparam int T = TICK_CYC_FAST;
`else
   localparam int T = TICK;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             clr;
   logic [PER_W-1:0] note_per;
   logic [DUR_W-1:0] note_dur;
   logic             note_over;
   logic             piezo;
   logic             piezo_n;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit m_active = 1'b0;
   int m_p = 0;
   int m_d = 0;
   int m_n = 0;

   piezo_drv #(
      .TICK_CYC (TICK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .note_per  (note_per),
      .note_dur  (note_dur),
      .note_over (note_over),
      .piezo     (piezo),
      .piezo_n   (piezo_n)
   );

   always #5 clk = ~clk;

   // Expected {note_over, piezo, piezo_n}
   function automatic logic [2:0] model_out();
      int over_at;
      bit hi;
      if (!m_active) return 3'b000;
      over_at = (m_d == 0) ? 2 : 1 + m_d * T;
      if (m_n >= over_at) return 3'b100;
      if (m_p < 2) return 3'b000;
      hi = ((m_n - 1) % m_p) < (m_p / 2);
      return hi ? 3'b010 : 3'b001;
   endfunction

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s n=%0d P=%0d D=%0d: observed=%b expected=%b",
                tag, m_n, m_p, m_d, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check(tag, {note_over, piezo, piezo_n}, model_out());
   endtask

   task automatic start_note(input int p, input int d, input string tag);
      note_per = PER_W'(p);
      note_dur = DUR_W'(d);
      clr      = 1'b1;
      @(posedge clk);
      #1;
      clr      = 1'b0;
      m_active = 1'b1;
      m_p      = p;
      m_d      = d;
      m_n      = 1;
      check_model(tag);
   endtask

   task automatic run(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         m_n++;
         check_model(tag);
      end
   endtask

   initial begin
      int p;
      int d;
      int len;

      rst      = 1'b1;
      clr      = 1'b0;
      note_per = '0;
      note_dur = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset", {note_over, piezo, piezo_n}, 3'b000);
      rst = 1'b0;

      // Idle must stay silent even with note inputs wiggling.
      note_per = PER_W'(8);
      note_dur = DUR_W'(1);
      run(5, "idle_hold");

      // Directed notes
      start_note(8, 3, "p8_d3_start");
      run(3 * T + 8, "p8_d3");
      start_note(7, 2, "p7_d2_start");    // also clr during OVER
      run(2 * T + 6, "p7_d2");
      start_note(0, 2, "rest_p0");
      run(2 * T + 4, "rest_p0");
      start_note(1, 1, "rest_p1");
      run(T + 4, "rest_p1");
      start_note(8, 0, "d0_start");
      run(5, "d0");
      start_note(2, 1, "p2");
      run(T + 3, "p2");

      // Restart mid-note: second clr 13 edges after the first
      start_note(8, 3, "restart_first");
      run(12, "restart_pre");
      start_note(8, 3, "restart_second");
      run(3 * T + 5, "restart_post");

      // Duration lowered below the running count -> OVER on the next edge
      start_note(8, 5, "lower_start");
      run(T + 4, "lower_pre");
      note_dur = '0;
      @(posedge clk);
      #1;
      check("lower_dur", {note_over, piezo, piezo_n}, 3'b100);

      // rst together with clr mid-note: reset wins, stays silent afterwards
      start_note(6, 4, "rstclr_start");
      run(7, "rstclr_pre");
      rst = 1'b1;
      clr = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      clr      = 1'b0;
      m_active = 1'b0;
      check("rst_over_clr", {note_over, piezo, piezo_n}, 3'b000);
      run(T + 5, "post_rst_idle");

      // Longest duration
      start_note(5, 255, "d255_start");
      run(255 * T + 3, "d255");

      // Randomized notes, some cut short by a new clr
      for (int k = 0; k < 16; k++) begin
         p = $urandom_range(0, 40);
         d = $urandom_range(0, 4);
         start_note(p, d, "rand_start");
         if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 3 * T);
         else                           len = d * T + 4;
         run(len, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
